// File: rtl/i2c_poll_collector_pkg.sv
// i2c_poll_collector_pkg
//   Shared definitions for the I2C poll collector: FSM state encodings,
//   default FIFO depth, sticky-flag bit positions and a pointer-width helper.
//   No ports.
package i2c_poll_collector_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT_D1 = 3'd2,
        ST_WAIT_D2 = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    localparam int FIFO_DEPTH_DEFAULT = 4;

    // Bit positions inside the sticky flag vector
    localparam int FLAG_W      = 4;
    localparam int FLG_TIMEOUT = 0;
    localparam int FLG_SEQ     = 1;
    localparam int FLG_D1_OVF  = 2;
    localparam int FLG_D2_OVF  = 3;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/i2c_poll_fifo.sv
// i2c_poll_fifo
//   First-word-fall-through FIFO holding one poll domain's bytes.
//   DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push, wr_data : write request and byte
//   pop           : remove head (ignored when empty)
//   rd_data       : head byte, 8'h00 while empty
//   empty, full   : occupancy status
//   drop          : one-cycle pulse when a push was discarded (full, no pop)
module i2c_poll_fifo
    import i2c_poll_collector_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic             drop
);

    localparam int             AW       = ptr_width(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok   = pop && !empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok  = push && (!full || pop_ok);
        drop     = push && !push_ok;

        if (push_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        // Storage needs no reset: rd_data is forced to zero while empty.
        mem_q <= mem_d;
    end

endmodule

// File: rtl/i2c_poll_collector.sv
// i2c_poll_collector
//   Periodically kicks an I2C world top, collects the two bytes it returns
//   (D1 then D2) into per-domain FIFOs and tracks protocol/timeout errors.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   enable                : permits new poll rounds (never aborts one)
//   start_o               : one-cycle start pulse to the world top
//   rd_data_i, valid_i    : returned byte and its qualifier
//   done_i                : round complete (must coincide with the D2 byte)
//   d1_*/d2_*             : FIFO pop, head data, empty/full, sticky overflow
//   timeout_err, seq_err  : sticky error flags; err_clr clears all sticky flags
//   busy                  : high whenever the FSM is not IDLE
//   round_cnt             : completed rounds, wraps 255 -> 0
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for enable
// START   | start_o pulse, timeout counter cleared
// WAIT_D1 | waiting for first byte (valid_i without done_i)
// WAIT_D2 | waiting for second byte together with done_i
// HOLD    | POLL_GAP cycle gap before returning to IDLE
module i2c_poll_collector
    import i2c_poll_collector_pkg::*;
#(
    parameter logic [15:0] POLL_GAP   = 16'd1000,
    parameter logic [21:0] TIMEOUT    = 22'd3000000,
    parameter int          FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic       start_o,
    input  logic [7:0] rd_data_i,
    input  logic       valid_i,
    input  logic       done_i,
    input  logic       d1_rd_en,
    input  logic       d2_rd_en,
    output logic [7:0] d1_data,
    output logic [7:0] d2_data,
    output logic       d1_empty,
    output logic       d2_empty,
    output logic       d1_full,
    output logic       d2_full,
    output logic       d1_ovf,
    output logic       d2_ovf,
    output logic       timeout_err,
    output logic       seq_err,
    input  logic       err_clr,
    output logic       busy,
    output logic [7:0] round_cnt
);

    state_t              state_q, state_d;
    logic [21:0]         tmo_cnt_q, tmo_cnt_d;
    logic [15:0]         gap_cnt_q, gap_cnt_d;
    logic [7:0]          round_cnt_q, round_cnt_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic                push_d1, push_d2;
    logic                seq_evt, tmo_evt;
    logic                d1_drop, d2_drop;

    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = tmo_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        round_cnt_d = round_cnt_q;
        start_o     = 1'b0;
        push_d1     = 1'b0;
        push_d2     = 1'b0;
        seq_evt     = 1'b0;
        tmo_evt     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                seq_evt = valid_i || done_i;
                if (enable) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                start_o   = 1'b1;
                tmo_cnt_d = '0;
                seq_evt   = valid_i || done_i;
                state_d   = ST_WAIT_D1;
            end
            ST_WAIT_D1: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (done_i) begin
                    seq_evt = 1'b1;
                    state_d = ST_HOLD;
                end else if (valid_i) begin
                    push_d1 = 1'b1;
                    state_d = ST_WAIT_D2;
                end
            end
            ST_WAIT_D2: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (valid_i && done_i) begin
                    push_d2     = 1'b1;
                    round_cnt_d = round_cnt_q + 1'b1;
                    state_d     = ST_HOLD;
                end else if (valid_i || done_i) begin
                    seq_evt = 1'b1;
                    if (done_i) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                seq_evt = valid_i || done_i;
                // Down-counter: HOLD lasts POLL_GAP cycles (at least one).
                if (gap_cnt_q <= 16'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Timeout only fires when the wait state saw no transition this cycle;
        // it trips in the TIMEOUT-th cycle after the start_o cycle.
        if ((state_q == ST_WAIT_D1 || state_q == ST_WAIT_D2) &&
            (state_d == state_q) && (tmo_cnt_d >= TIMEOUT)) begin
            tmo_evt = 1'b1;
            state_d = ST_HOLD;
        end

        if (state_d == ST_HOLD && state_q != ST_HOLD) begin
            gap_cnt_d = POLL_GAP;
        end
    end

    // Clear first, then OR in events so a same-cycle event wins over err_clr.
    always_comb begin
        flags_d = err_clr ? '0 : flags_q;
        if (tmo_evt) flags_d[FLG_TIMEOUT] = 1'b1;
        if (seq_evt) flags_d[FLG_SEQ]     = 1'b1;
        if (d1_drop) flags_d[FLG_D1_OVF]  = 1'b1;
        if (d2_drop) flags_d[FLG_D2_OVF]  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tmo_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            round_cnt_q <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            round_cnt_q <= round_cnt_d;
            flags_q     <= flags_d;
        end
    end

    i2c_poll_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo_d1 (
        .clk     (clk),
        .rst     (rst),
        .push    (push_d1),
        .wr_data (rd_data_i),
        .pop     (d1_rd_en),
        .rd_data (d1_data),
        .empty   (d1_empty),
        .full    (d1_full),
        .drop    (d1_drop)
    );

    i2c_poll_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo_d2 (
        .clk     (clk),
        .rst     (rst),
        .push    (push_d2),
        .wr_data (rd_data_i),
        .pop     (d2_rd_en),
        .rd_data (d2_data),
        .empty   (d2_empty),
        .full    (d2_full),
        .drop    (d2_drop)
    );

    assign busy        = (state_q != ST_IDLE);
    assign round_cnt   = round_cnt_q;
    assign timeout_err = flags_q[FLG_TIMEOUT];
    assign seq_err     = flags_q[FLG_SEQ];
    assign d1_ovf      = flags_q[FLG_D1_OVF];
    assign d2_ovf      = flags_q[FLG_D2_OVF];

endmodule

// File: tb/tb_i2c_poll_collector.sv
// tb_i2c_poll_collector
//   Directed bench for i2c_poll_collector with a short gap and timeout.
module tb_i2c_poll_collector;

    localparam logic [15:0] GAP   = 16'd5;
    localparam logic [21:0] TMO   = 22'd20;
    localparam int          DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, enable, start_o, valid_i, done_i;
    logic       d1_rd_en, d2_rd_en, err_clr, busy;
    logic [7:0] rd_data_i, d1_data, d2_data, round_cnt;
    logic       d1_empty, d2_empty, d1_full, d2_full, d1_ovf, d2_ovf;
    logic       timeout_err, seq_err;

    int n_chk  = 0;
    int n_pass = 0;
    int start_seen = 0;

    i2c_poll_collector #(.POLL_GAP(GAP), .TIMEOUT(TMO), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .start_o     (start_o),
        .rd_data_i   (rd_data_i),
        .valid_i     (valid_i),
        .done_i      (done_i),
        .d1_rd_en    (d1_rd_en),
        .d2_rd_en    (d2_rd_en),
        .d1_data     (d1_data),
        .d2_data     (d2_data),
        .d1_empty    (d1_empty),
        .d2_empty    (d2_empty),
        .d1_full     (d1_full),
        .d2_full     (d2_full),
        .d1_ovf      (d1_ovf),
        .d2_ovf      (d2_ovf),
        .timeout_err (timeout_err),
        .seq_err     (seq_err),
        .err_clr     (err_clr),
        .busy        (busy),
        .round_cnt   (round_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (start_o === 1'b1) start_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic wait_start();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (start_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) chk("start_wait", 32'd0, 32'd1);
    endtask

    // One clean round; leaves the FSM in its first HOLD cycle.
    task automatic do_round(input logic [7:0] a, input logic [7:0] b, input logic pop1);
        enable = 1'b1;
        wait_start();
        enable = 1'b0;
        tick();
        valid_i   = 1'b1;
        rd_data_i = a;
        d1_rd_en  = pop1;
        tick();
        rd_data_i = b;
        done_i    = 1'b1;
        d1_rd_en  = 1'b0;
        tick();
        valid_i = 1'b0;
        done_i  = 1'b0;
    endtask

    initial begin
        int s0;
        rst = 1'b1; enable = 1'b0; valid_i = 1'b0; done_i = 1'b0;
        d1_rd_en = 1'b0; d2_rd_en = 1'b0; err_clr = 1'b0; rd_data_i = 8'h00;
        repeat (2) tick();
        chk("rst_busy",   32'(busy),      32'd0);
        chk("rst_start",  32'(start_o),   32'd0);
        chk("rst_rcnt",   32'(round_cnt), 32'd0);
        chk("rst_d1_emp", 32'(d1_empty),  32'd1);
        chk("rst_d1_ful", 32'(d1_full),   32'd0);
        chk("rst_d1_dat", 32'(d1_data),   32'h00);
        chk("rst_d2_emp", 32'(d2_empty),  32'd1);
        chk("rst_flags",  32'({timeout_err, seq_err, d1_ovf, d2_ovf}), 32'd0);
        rst = 1'b0;
        tick();

        // Basic round
        s0 = start_seen;
        do_round(8'h12, 8'h90, 1'b0);
        chk("r1_d1",     32'(d1_data),   32'h12);
        chk("r1_d2",     32'(d2_data),   32'h90);
        chk("r1_rcnt",   32'(round_cnt), 32'd1);
        chk("r1_starts", start_seen - s0, 32'd1);
        chk("r1_seq",    32'(seq_err),   32'd0);
        // HOLD lasts GAP cycles, then IDLE; enable low keeps it there
        repeat (GAP - 1) tick();
        chk("hold_busy", 32'(busy), 32'd1);
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        chk("no_restart", start_seen - s0, 32'd1);

        // Pop both, then pop empty
        d1_rd_en = 1'b1; d2_rd_en = 1'b1;
        tick();
        chk("pop_d1_emp", 32'(d1_empty), 32'd1);
        chk("pop_d1_dat", 32'(d1_data),  32'h00);
        tick();
        d1_rd_en = 1'b0; d2_rd_en = 1'b0;
        chk("pop_empty_dat", 32'(d2_data), 32'h00);
        chk("pop_empty_ovf", 32'(d1_ovf),  32'd0);

        // Five rounds with no pops
        for (int i = 0; i < 5; i++) begin
            do_round(8'hA0 + 8'(i), 8'hB0 + 8'(i), 1'b0);
            if (i == 3) begin
                chk("r4_full", 32'(d1_full), 32'd1);
                chk("r4_ovf",  32'(d1_ovf),  32'd0);
            end
        end
        chk("r5_d1_ovf",  32'(d1_ovf),    32'd1);
        chk("r5_d2_ovf",  32'(d2_ovf),    32'd1);
        chk("r5_d1_head", 32'(d1_data),   32'hA0);
        chk("r5_d2_head", 32'(d2_data),   32'hB0);
        chk("r5_rcnt",    32'(round_cnt), 32'd6);

        // Full FIFO, push and pop in the same cycle
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_ovf", 32'({d1_ovf, d2_ovf}), 32'd0);
        do_round(8'hC5, 8'hD5, 1'b1);
        chk("pp_full",   32'(d1_full),   32'd1);
        chk("pp_ovf",    32'(d1_ovf),    32'd0);
        chk("pp_head",   32'(d1_data),   32'hA1);
        chk("pp_d2_ovf", 32'(d2_ovf),    32'd1);
        chk("pp_rcnt",   32'(round_cnt), 32'd7);
        d1_rd_en = 1'b1;
        tick();
        chk("pp_pop1", 32'(d1_data), 32'hA2);
        tick();
        chk("pp_pop2", 32'(d1_data), 32'hA3);
        tick();
        chk("pp_tail", 32'(d1_data), 32'hC5);
        tick();
        d1_rd_en = 1'b0;
        chk("pp_empty", 32'(d1_empty), 32'd1);
        repeat (8) tick();

        // Timeout: start cycle is cycle 0, trips in cycle TMO
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        enable = 1'b1;
        wait_start();
        enable = 1'b0;
        repeat (TMO) tick();
        chk("tmo_before", 32'(timeout_err), 32'd0);
        tick();
        chk("tmo_flag", 32'(timeout_err), 32'd1);
        chk("tmo_busy", 32'(busy),        32'd1);
        chk("tmo_rcnt", 32'(round_cnt),   32'd7);
        enable = 1'b1;
        repeat (GAP) tick();
        chk("tmo_gap_nostart", 32'(start_o), 32'd0);
        tick();
        chk("tmo_restart", 32'(start_o), 32'd1);
        enable = 1'b0;

        // done_i in WAIT_D1
        tick();
        valid_i = 1'b1; done_i = 1'b1; rd_data_i = 8'h77;
        tick();
        valid_i = 1'b0; done_i = 1'b0;
        chk("seq_flag",   32'(seq_err),  32'd1);
        chk("seq_nopush", 32'(d1_empty), 32'd1);
        chk("seq_hold",   32'(busy),     32'd1);
        // err_clr with a same-cycle seq event: event wins
        err_clr = 1'b1; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        chk("setwins_seq", 32'(seq_err),     32'd1);
        chk("clr_tmo",     32'(timeout_err), 32'd0);
        tick();
        err_clr = 1'b0;
        chk("clr_seq", 32'(seq_err), 32'd0);
        repeat (8) tick();

        // Reset in WAIT_D2
        enable = 1'b1;
        wait_start();
        enable = 1'b0;
        tick();
        valid_i = 1'b1; rd_data_i = 8'h55;
        tick();
        valid_i = 1'b0;
        chk("mid_d1_nonempty", 32'(d1_empty), 32'd0);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy",  32'(busy),      32'd0);
        chk("mid_rst_emp",   32'(d1_empty),  32'd1);
        chk("mid_rst_d2emp", 32'(d2_empty),  32'd1);
        chk("mid_rst_rcnt",  32'(round_cnt), 32'd0);
        chk("mid_rst_dat",   32'(d1_data),   32'h00);
        rst = 1'b0;
        tick();
        chk("post_rst_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
